// File: rtl/paper_cpu_if.sv
// Bus between paper_cpu and its environment: run handshake, program ROM port
// and the observable machine state.
interface paper_cpu_if #(
    parameter int DATA_W = 2,
    parameter int ADDR_W = 2,
    parameter int CNT_W  = 8
);
    logic              start;
    logic [ADDR_W-1:0] instr_addr;
    logic [ADDR_W+2:0] instr_data;
    logic [DATA_W-1:0] acc;
    logic              ovf;
    logic              busy;
    logic              halted;
    logic [CNT_W-1:0]  retired;

    modport master (
        input  start, instr_data,
        output instr_addr, acc, ovf, busy, halted, retired
    );

    modport slave (
        output start, instr_data,
        input  instr_addr, acc, ovf, busy, halted, retired
    );
endinterface

// File: rtl/paper_cpu.sv
// Multi-cycle accumulator machine: FETCH/EXEC per instruction, start/halt
// handshake, wrap flag on INC/DEC and a saturating retired-instruction counter.
module paper_cpu #(
    parameter int DATA_W = 2,
    parameter int ADDR_W = 2,
    parameter int CNT_W  = 8
) (
    input  logic        clk,
    input  logic        reset,
    paper_cpu_if.master bus
);
    localparam logic [2:0] OP_INC = 3'b000;
    localparam logic [2:0] OP_DEC = 3'b001;
    localparam logic [2:0] OP_JNO = 3'b010;
    localparam logic [2:0] OP_JMP = 3'b011;
    localparam logic [2:0] OP_CLR = 3'b100;
    localparam logic [2:0] OP_HLT = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_HALT
    } state_t;

    state_t            state_reg;
    logic [ADDR_W-1:0] pc_reg;
    logic [ADDR_W+2:0] ir_reg;
    logic [DATA_W-1:0] acc_reg;
    logic              ovf_reg;
    logic [CNT_W-1:0]  retired_reg;
    logic              busy_reg;
    logic              halted_reg;

    logic [2:0]        op;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] pc_inc;

    assign op     = ir_reg[ADDR_W+2:ADDR_W];
    assign target = ir_reg[ADDR_W-1:0];
    assign pc_inc = pc_reg + ADDR_W'(1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg   <= S_IDLE;
            pc_reg      <= '0;
            ir_reg      <= '0;
            acc_reg     <= '0;
            ovf_reg     <= 1'b0;
            retired_reg <= '0;
            busy_reg    <= 1'b0;
            halted_reg  <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE, S_HALT: begin
                    // A (re)start clears the whole architectural state
                    if (bus.start) begin
                        state_reg   <= S_FETCH;
                        pc_reg      <= '0;
                        acc_reg     <= '0;
                        ovf_reg     <= 1'b0;
                        retired_reg <= '0;
                        busy_reg    <= 1'b1;
                        halted_reg  <= 1'b0;
                    end
                end
                S_FETCH: begin
                    ir_reg    <= bus.instr_data;
                    state_reg <= S_EXEC;
                end
                S_EXEC: begin
                    if (retired_reg != '1) begin
                        retired_reg <= retired_reg + CNT_W'(1);
                    end
                    state_reg <= S_FETCH;
                    pc_reg    <= pc_inc;
                    case (op)
                        OP_INC: begin
                            acc_reg <= acc_reg + DATA_W'(1);
                            ovf_reg <= (acc_reg == '1);
                        end
                        OP_DEC: begin
                            acc_reg <= acc_reg - DATA_W'(1);
                            ovf_reg <= (acc_reg == '0);
                        end
                        OP_JNO: begin
                            if (!ovf_reg) begin
                                pc_reg <= target;
                            end
                        end
                        OP_JMP: pc_reg <= target;
                        OP_CLR: begin
                            acc_reg <= '0;
                            ovf_reg <= 1'b0;
                        end
                        OP_HLT: begin
                            // PC stays on the HLT so the halt address is visible
                            pc_reg     <= pc_reg;
                            state_reg  <= S_HALT;
                            busy_reg   <= 1'b0;
                            halted_reg <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign bus.instr_addr = pc_reg;
    assign bus.acc        = acc_reg;
    assign bus.ovf        = ovf_reg;
    assign bus.busy       = busy_reg;
    assign bus.halted     = halted_reg;
    assign bus.retired    = retired_reg;
endmodule

// File: tb/tb_paper_cpu.sv
// Directed bench for paper_cpu: three parameterisations, step tables for the
// long programs and hand-written sequences for start/reset corner cases.
module tb_paper_cpu;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    paper_cpu_if #(.DATA_W(2), .ADDR_W(2), .CNT_W(8)) if0 ();
    paper_cpu_if #(.DATA_W(4), .ADDR_W(2), .CNT_W(8)) if1 ();
    paper_cpu_if #(.DATA_W(2), .ADDR_W(2), .CNT_W(2)) if2 ();

    paper_cpu #(.DATA_W(2), .ADDR_W(2), .CNT_W(8)) u0 (.clk(clk), .reset(reset), .bus(if0.master));
    paper_cpu #(.DATA_W(4), .ADDR_W(2), .CNT_W(8)) u1 (.clk(clk), .reset(reset), .bus(if1.master));
    paper_cpu #(.DATA_W(2), .ADDR_W(2), .CNT_W(2)) u2 (.clk(clk), .reset(reset), .bus(if2.master));

    logic [4:0] rom0 [4];
    logic [4:0] rom1 [4];
    logic [4:0] rom2 [4];

    assign if0.instr_data = rom0[if0.instr_addr];
    assign if1.instr_data = rom1[if1.instr_addr];
    assign if2.instr_data = rom2[if2.instr_addr];

    function automatic logic [4:0] enc(input logic [2:0] op, input logic [1:0] tgt);
        return {op, tgt};
    endfunction

    typedef struct {
        int         cycles;
        logic [1:0] acc;
        logic       ovf;
        logic [1:0] pc;
        logic [7:0] retired;
        logic       busy;
        logic       halted;
    } vec_t;

    vec_t tab_loop [10];
    vec_t tab_wrap [8];

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_u0(input string tag, input int idx, input vec_t v);
        tick(v.cycles);
        chk($sformatf("%s[%0d].acc", tag, idx), int'(if0.acc), int'(v.acc));
        chk($sformatf("%s[%0d].ovf", tag, idx), int'(if0.ovf), int'(v.ovf));
        chk($sformatf("%s[%0d].pc", tag, idx), int'(if0.instr_addr), int'(v.pc));
        chk($sformatf("%s[%0d].retired", tag, idx), int'(if0.retired), int'(v.retired));
        chk($sformatf("%s[%0d].busy", tag, idx), int'(if0.busy), int'(v.busy));
        chk($sformatf("%s[%0d].halted", tag, idx), int'(if0.halted), int'(v.halted));
        $display("%s step %0d: acc=%0d ovf=%0d pc=%0d retired=%0d busy=%0d halted=%0d",
                 tag, idx, if0.acc, if0.ovf, if0.instr_addr, if0.retired, if0.busy, if0.halted);
    endtask

    task automatic chk_u1_done(input string tag);
        chk({tag, ".acc"}, int'(if1.acc), 15);
        chk({tag, ".ovf"}, int'(if1.ovf), 1);
        chk({tag, ".pc"}, int'(if1.instr_addr), 2);
        chk({tag, ".retired"}, int'(if1.retired), 3);
        chk({tag, ".halted"}, int'(if1.halted), 1);
        chk({tag, ".busy"}, int'(if1.busy), 0);
        $display("%s: acc=%0d ovf=%0d pc=%0d retired=%0d", tag, if1.acc, if1.ovf, if1.instr_addr, if1.retired);
    endtask

    initial begin
        // INC / JNO 0 loop: acc counts to wrap, then JNO falls through twice to HLT
        tab_loop[0] = '{2, 2'd1, 1'b0, 2'd1, 8'd1,  1'b1, 1'b0};
        tab_loop[1] = '{2, 2'd1, 1'b0, 2'd0, 8'd2,  1'b1, 1'b0};
        tab_loop[2] = '{2, 2'd2, 1'b0, 2'd1, 8'd3,  1'b1, 1'b0};
        tab_loop[3] = '{2, 2'd2, 1'b0, 2'd0, 8'd4,  1'b1, 1'b0};
        tab_loop[4] = '{2, 2'd3, 1'b0, 2'd1, 8'd5,  1'b1, 1'b0};
        tab_loop[5] = '{2, 2'd3, 1'b0, 2'd0, 8'd6,  1'b1, 1'b0};
        tab_loop[6] = '{2, 2'd0, 1'b1, 2'd1, 8'd7,  1'b1, 1'b0};
        tab_loop[7] = '{2, 2'd0, 1'b1, 2'd2, 8'd8,  1'b1, 1'b0};
        tab_loop[8] = '{2, 2'd0, 1'b1, 2'd3, 8'd9,  1'b1, 1'b0};
        tab_loop[9] = '{2, 2'd0, 1'b1, 2'd3, 8'd10, 1'b0, 1'b1};
        // INC,INC,INC,CLR: PC wraps 3->0, CLR keeps ovf low
        for (int i = 0; i < 8; i++) begin
            tab_wrap[i] = '{2, 2'((i + 1) % 4), 1'b0, 2'((i + 1) % 4), 8'(i + 1), 1'b1, 1'b0};
        end

        rom0[0] = enc(3'b000, 2'd0);
        rom0[1] = enc(3'b010, 2'd0);
        rom0[2] = enc(3'b010, 2'd0);
        rom0[3] = enc(3'b101, 2'd0);
        rom1[0] = enc(3'b001, 2'd0);
        rom1[1] = enc(3'b010, 2'd3);
        rom1[2] = enc(3'b101, 2'd0);
        rom1[3] = enc(3'b101, 2'd0);
        rom2[0] = enc(3'b110, 2'd0);
        rom2[1] = enc(3'b011, 2'd0);
        rom2[2] = enc(3'b111, 2'd0);
        rom2[3] = enc(3'b111, 2'd0);

        if0.start = 1'b0;
        if1.start = 1'b0;
        if2.start = 1'b0;
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(1);
        chk("rst.acc", int'(if0.acc), 0);
        chk("rst.ovf", int'(if0.ovf), 0);
        chk("rst.pc", int'(if0.instr_addr), 0);
        chk("rst.busy", int'(if0.busy), 0);
        chk("rst.halted", int'(if0.halted), 0);
        chk("rst.retired", int'(if0.retired), 0);
        $display("reset: acc=%0d pc=%0d busy=%0d halted=%0d", if0.acc, if0.instr_addr, if0.busy, if0.halted);

        // Counting loop on DATA_W=2
        if0.start = 1'b1;
        tick(1);
        if0.start = 1'b0;
        chk("loop.start.busy", int'(if0.busy), 1);
        for (int i = 0; i < 10; i++) apply_u0("loop", i, tab_loop[i]);

        // DEC wrap on DATA_W=4, then restart gives the same result
        if1.start = 1'b1;
        tick(1);
        if1.start = 1'b0;
        tick(6);
        chk_u1_done("dec1");
        if1.start = 1'b1;
        tick(1);
        if1.start = 1'b0;
        chk("dec.restart.retired", int'(if1.retired), 0);
        chk("dec.restart.acc", int'(if1.acc), 0);
        chk("dec.restart.ovf", int'(if1.ovf), 0);
        chk("dec.restart.busy", int'(if1.busy), 1);
        tick(6);
        chk_u1_done("dec2");

        // Reset during EXEC of the second instruction
        if0.start = 1'b1;
        tick(1);
        if0.start = 1'b0;
        tick(3);
        chk("midrst.pre.pc", int'(if0.instr_addr), 1);
        reset = 1'b0;
        tick(1);
        chk("midrst.acc", int'(if0.acc), 0);
        chk("midrst.pc", int'(if0.instr_addr), 0);
        chk("midrst.retired", int'(if0.retired), 0);
        chk("midrst.busy", int'(if0.busy), 0);
        chk("midrst.halted", int'(if0.halted), 0);
        chk("midrst.u1.halted", int'(if1.halted), 0);
        reset = 1'b1;
        tick(3);
        chk("idle.busy", int'(if0.busy), 0);
        chk("idle.pc", int'(if0.instr_addr), 0);
        $display("mid-exec reset: acc=%0d pc=%0d busy=%0d", if0.acc, if0.instr_addr, if0.busy);

        // start held high: ignored while busy, restarts straight out of HALT
        if1.start = 1'b1;
        tick(1);
        chk("hold.E.busy", int'(if1.busy), 1);
        tick(2);
        chk("hold.k1.retired", int'(if1.retired), 1);
        tick(2);
        chk("hold.k2.retired", int'(if1.retired), 2);
        chk("hold.k2.busy", int'(if1.busy), 1);
        tick(2);
        chk_u1_done("hold.halt");
        tick(1);
        chk("hold.restart.busy", int'(if1.busy), 1);
        chk("hold.restart.halted", int'(if1.halted), 0);
        chk("hold.restart.retired", int'(if1.retired), 0);
        if1.start = 1'b0;
        $display("held start: restart busy=%0d retired=%0d", if1.busy, if1.retired);

        // NOP/JMP loop with a 2-bit counter saturates
        if2.start = 1'b1;
        tick(1);
        if2.start = 1'b0;
        tick(4);
        chk("sat.c4.retired", int'(if2.retired), 2);
        tick(2);
        chk("sat.c6.retired", int'(if2.retired), 3);
        tick(4);
        chk("sat.c10.retired", int'(if2.retired), 3);
        chk("sat.acc", int'(if2.acc), 0);
        chk("sat.busy", int'(if2.busy), 1);
        chk("sat.halted", int'(if2.halted), 0);
        $display("saturate: retired=%0d busy=%0d", if2.retired, if2.busy);

        // PC wrap program on u0
        rom0[0] = enc(3'b000, 2'd0);
        rom0[1] = enc(3'b000, 2'd0);
        rom0[2] = enc(3'b000, 2'd0);
        rom0[3] = enc(3'b100, 2'd0);
        if0.start = 1'b1;
        tick(1);
        if0.start = 1'b0;
        for (int i = 0; i < 8; i++) apply_u0("wrap", i, tab_wrap[i]);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/paper_cpu.md
# paper_cpu

Parametrised successor to the 2-bit paper processor: a multi-cycle accumulator machine with a program counter, an instruction register, an accumulator with wrap/overflow flag, and a start/halt handshake. It fetches from an external combinational program ROM (same role as the existing `ram`) and executes a small instruction set in which INC, JNO and HLT are a subset. Generalised in data width, program depth and instruction set. It also keeps a retired-instruction counter for bench checking.

## Interface
- `DATA_W`, 2: accumulator width (>=1)
- `ADDR_W`, 2: program address width; depth = 2^ADDR_W
- `CNT_W`, 8: retired-instruction counter width
- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-low reset
- `start`  in  1  run request, sampled in IDLE/HALT only
- `instr_addr`  out  ADDR_W  program address (= PC)
- `instr_data`  in  3+ADDR_W  instruction word from ROM, valid combinationally for `instr_addr`
- `acc`  out  DATA_W  accumulator
- `ovf`  out  1  overflow/borrow flag
- `busy`  out  1  high in FETCH/EXEC
- `halted`  out  1  high in HALT
- `retired`  out  CNT_W  instructions retired since last start, saturating

## Operation
- Instruction word: opcode = `instr_data[ADDR_W+2:ADDR_W]`, target = `instr_data[ADDR_W-1:0]`.
- Opcodes: 000 INC (acc+1); 001 DEC (acc-1); 010 JNO (if ovf==0 PC<=target, else PC+1); 011 JMP (PC<=target); 100 CLR (acc<=0, ovf<=0); 101 HLT; 110/111 NOP.
- INC/DEC: acc wraps modulo 2^DATA_W; ovf<=1 if INC wraps all-ones->0 or DEC wraps 0->all-ones, else ovf<=0. Other opcodes leave ovf unchanged (except CLR).
- Non-jump instructions: PC<=PC+1, wrapping 2^ADDR_W-1 -> 0.
- FSM states: IDLE, FETCH, EXEC, HALT.
  - IDLE: start=1 -> FETCH; PC, acc, ovf, retired cleared on that edge.
  - FETCH: IR<=instr_data -> EXEC.
  - EXEC: execute IR, retired<=retired+1 (saturate at 2^CNT_W-1); HLT -> HALT (PC not advanced), else -> FETCH.
  - HALT: holds all state; start=1 -> FETCH with same clearing as IDLE.
- start in FETCH/EXEC ignored.
- HLT counts as retired.
- reset=0 overrides everything, including mid-instruction.

## Timing
- Reset (sampled low at edge): state=IDLE, PC=0, IR=0, acc=0, ovf=0, retired=0, busy=0, halted=0; instr_addr=0.
- All outputs registered-state driven; no combinational path from start or instr_data to any output.
- start accepted at edge E: busy=1 from E; each instruction = 2 cycles (FETCH, EXEC); results of instruction k visible after its EXEC edge.
- Program of N retired instructions ending in HLT: halted=1, busy=0 exactly 2N cycles after E.
- instr_data sampled only at the FETCH edge; changes at other times have no effect.

## Test plan
- DATA_W=2, ADDR_W=2, ROM {0:INC, 1:JNO 0, 2:JNO 0, 3:HLT}, start pulse -> acc 1,2,3,0; ovf=1 after 4th INC; halted 20 cycles after start accepted; final acc=0, ovf=1, PC=3, retired=10.
- DATA_W=4, ROM {0:DEC, 1:JNO 3, 2:HLT, 3:HLT} -> acc=15, ovf=1, JNO falls through, halts at PC=2, retired=3; then start again -> counters cleared, identical result.
- Reset driven low during EXEC of 2nd instruction -> next edge all outputs at reset values, state IDLE; start not asserted -> stays idle, instr_addr=0.
- start held high throughout run -> no restart while busy; after HLT, held start restarts on next edge (busy=1, retired=0).
- CNT_W=2, ROM {0:NOP, 1:JMP 0} run 10 cycles -> retired saturates at 3, acc unchanged 0, busy stays 1.
- ADDR_W=2, ROM {0:INC,1:INC,2:INC,3:CLR} -> PC wraps 3->0, acc pattern 1,2,3,0,1…, ovf never set, never halts.
